adc_sar_responder: RTL and testbench
====================================

Name: adc_sar_responder

Overview:
- Converter-side responder for the acquisition start/end-of-conversion handshake. It models a successive-approximation ADC.
- It accepts a start-of-conversion request, samples a digital stand-in for the analog input, and resolves one result bit per step, MSB first.
- It then raises eoc and holds the result until it is read.
- It sits opposite the acquisition controller FSM, supplying the eoc that controller waits on. It serves both as a synthesizable converter front-end and as the bench responder.

Parameters:
- DATA_W, 8, result width in bits (2..16).
- STEP_DIV, 1, clock cycles per SAR bit decision (1..255).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- soc, input, 1, start of conversion; level, sampled on clk rising edge.
- ain, input, DATA_W, input value to convert; sampled once per conversion.
- rd, input, 1, result read strobe; sampled on clk.
- busy, output, 1, high while sampling or converting.
- eoc, output, 1, end of conversion; high while an unread result is valid.
- dout, output, DATA_W, conversion result.
- ovr, output, 1, sticky overrun flag.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, busy=0, eoc=0, dout=0, ovr=0. Internal hold, trial result, bit index and step counter are all 0.
- State machine: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - soc=1 -> SAMPLE; busy=1.
- SAMPLE (exactly 1 cycle):
  - hold <= ain; result <= 0; bit index <= DATA_W-1; step counter <= 0; -> CONV.
- CONV:
  - The step counter counts 0..STEP_DIV-1.
  - On the edge where counter == STEP_DIV-1: trial = result | (1 << idx); if trial <= hold (unsigned), result <= trial, else result unchanged. Then idx decrements and the counter returns to 0.
  - After the idx==0 decision: -> DONE; dout <= final result; eoc=1; busy=0.
- DONE:
  - rd=1 -> eoc=0, -> IDLE; dout holds its value.
  - soc=1 with rd=0 -> result discarded, ovr=1, eoc=0, -> SAMPLE.
  - soc=1 and rd=1 on the same edge -> read wins for ovr purposes (ovr unchanged), eoc=0, -> SAMPLE.
- Latency:
  - soc sampled at edge N -> eoc high after edge N+1+DATA_W*STEP_DIV.
  - With defaults, eoc rises after edge N+9.
- The ideal SAR result equals the sampled hold value for every input, 0 through 2^DATA_W-1.
- ain changes after the SAMPLE edge do not affect the result.
- soc while in SAMPLE or CONV: ignored. The conversion continues and ovr=1.
- rd while not in DONE: ignored. No effect on eoc, dout or ovr.
- ovr is sticky. It is cleared only by a rd sampled while in DONE with soc=0, or by rst.
- soc held high continuously: back-to-back conversions, each re-armed from DONE. Every completed conversion that is not read sets ovr.
- rst asserted mid-conversion: immediate return to reset values. Any partial result is lost. No eoc pulse occurs.
- Unlisted or illegal state encodings -> IDLE.

Decomposition:
- Shared package adq_pkg contains:
  - the responder state enum (IDLE/SAMPLE/CONV/DONE);
  - the controller state constants for the acquisition FSM;
  - a default DATA_W constant, so controller, responder and benches agree on the handshake.
- One natural sub-module: sar_step_timer. It is the STEP_DIV prescaler, producing a one-cycle step strobe while enabled and reset to 0 on restart.
- The SAR register and comparison stay in the top module.

Test Plan:
- Reset, then soc=1 for one cycle with ain=8'hA5 -> busy=1 the next cycle; eoc=1 exactly 9 cycles after the soc edge; dout=8'hA5; ovr=0.
- STEP_DIV=3, ain=8'h00, then a second conversion with ain=8'hFF -> each eoc rises 25 cycles after its soc edge; dout=8'h00, then 8'hFF.
- soc with ain=8'h3C, ain changed to 8'hC3 two cycles later -> dout=8'h3C.
- Complete a conversion, assert soc in DONE without rd -> ovr=1, eoc drops, new result arrives. rd in the next DONE -> eoc=0, ovr=0.
- soc re-asserted during CONV (cycle 4) -> conversion timing unchanged, ovr=1, result correct.
- rst pulsed during CONV (cycle 5) -> busy=0, eoc=0, dout=0 immediately. A new soc then converts ain=8'h5A correctly.

Source files
------------

// File: rtl/adq_pkg.sv
// rtl/adq_pkg.sv - shared acquisition handshake types and constants
package adq_pkg;

    localparam int ADQ_DATA_W = 8;

    typedef enum logic [1:0] {
        RESP_IDLE   = 2'd0,
        RESP_SAMPLE = 2'd1,
        RESP_CONV   = 2'd2,
        RESP_DONE   = 2'd3
    } resp_state_e;

    // Acquisition controller states, kept here so both ends of the handshake agree
    localparam logic [2:0] CTL_IDLE     = 3'd0;
    localparam logic [2:0] CTL_START    = 3'd1;
    localparam logic [2:0] CTL_WAIT_EOC = 3'd2;
    localparam logic [2:0] CTL_READ     = 3'd3;
    localparam logic [2:0] CTL_STORE    = 3'd4;

endpackage

// File: rtl/sar_step_timer.sv
// rtl/sar_step_timer.sv - STEP_DIV prescaler giving one strobe per SAR bit decision
module sar_step_timer #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

    logic [7:0] cnt;

    assign step = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clr || !en || cnt == LAST) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_sar_responder.sv
// rtl/adc_sar_responder.sv - successive-approximation ADC responder with soc/eoc handshake
module adc_sar_responder
    import adq_pkg::*;
#(
    parameter int DATA_W   = ADQ_DATA_W,
    parameter int STEP_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soc,
    input  logic [DATA_W-1:0] ain,
    input  logic              rd,
    output logic              busy,
    output logic              eoc,
    output logic [DATA_W-1:0] dout,
    output logic              ovr
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
    localparam logic [DATA_W-1:0] BIT_ONE = DATA_W'(1);

    localparam logic [1:0] ST_IDLE   = RESP_IDLE;
    localparam logic [1:0] ST_SAMPLE = RESP_SAMPLE;
    localparam logic [1:0] ST_CONV   = RESP_CONV;
    localparam logic [1:0] ST_DONE   = RESP_DONE;

    logic [1:0]        state;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] result;
    logic [IDX_W-1:0]  idx;
    logic              step;
    logic [DATA_W-1:0] trial;
    logic [DATA_W-1:0] next_result;

    sar_step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_CONV),
        .clr (state == ST_SAMPLE),
        .step(step)
    );

    // Keep the trial bit only if the candidate does not exceed the held sample
    assign trial       = result | (BIT_ONE << idx);
    assign next_result = (trial <= hold) ? trial : result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            hold   <= '0;
            result <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            eoc    <= 1'b0;
            dout   <= '0;
            ovr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (soc) begin
                        state <= ST_SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    hold   <= ain;
                    result <= '0;
                    idx    <= IDX_MSB;
                    state  <= ST_CONV;
                    if (soc) ovr <= 1'b1;
                end
                ST_CONV: begin
                    if (soc) ovr <= 1'b1;
                    if (step) begin
                        result <= next_result;
                        if (idx == '0) begin
                            state <= ST_DONE;
                            dout  <= next_result;
                            eoc   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx - IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A read on the same edge as a restart still counts as consumed
                    if (soc) begin
                        eoc   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_SAMPLE;
                        if (!rd) ovr <= 1'b1;
                    end else if (rd) begin
                        eoc   <= 1'b0;
                        ovr   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    eoc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_responder.sv
// tb/tb_adc_sar_responder.sv - self-checking bench for adc_sar_responder
module tb_adc_sar_responder;

    logic       clk;
    logic       rst;
    logic       soc, rd, soc3, rd3;
    logic [7:0] ain, ain3;
    logic       busy, eoc, ovr, busy3, eoc3, ovr3;
    logic [7:0] dout, dout3;

    int n_checks = 0;
    int n_fail   = 0;

    adc_sar_responder dut (
        .clk(clk), .rst(rst), .soc(soc), .ain(ain), .rd(rd),
        .busy(busy), .eoc(eoc), .dout(dout), .ovr(ovr)
    );

    adc_sar_responder #(.DATA_W(8), .STEP_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .soc(soc3), .ain(ain3), .rd(rd3),
        .busy(busy3), .eoc(eoc3), .dout(dout3), .ovr(ovr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ain;
        logic [7:0] exp_dout;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_eoc(input int which);
        return (which == 0) ? eoc : eoc3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive soc for one edge, then count edges until eoc is seen; optional
    // ain scrambling after the sample edge and optional rd alongside soc.
    task automatic conv(input int which, input logic [7:0] a, input bit with_rd,
                        input bit scramble, output int lat);
        if (which == 0) begin soc = 1'b1; ain = a; rd = with_rd; end
        else            begin soc3 = 1'b1; ain3 = a; rd3 = with_rd; end
        tick();
        soc = 1'b0; rd = 1'b0; soc3 = 1'b0; rd3 = 1'b0;
        check("busy_after_soc", (which == 0) ? busy : busy3, 1'b1);
        lat = 0;
        while (!sel_eoc(which) && lat < 100) begin
            tick();
            lat++;
            if (scramble && lat >= 1) begin
                if (which == 0) ain = 8'($urandom);
                else            ain3 = 8'($urandom);
            end
        end
    endtask

    task automatic do_read(input int which);
        if (which == 0) rd = 1'b1; else rd3 = 1'b1;
        tick();
        rd = 1'b0; rd3 = 1'b0;
    endtask

    int         lat;
    logic [7:0] a;
    bit         pending;
    logic       ovr_exp;
    int         act;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 9};
        vecs[1] = '{8'h00, 8'h00, 9};
        vecs[2] = '{8'hFF, 8'hFF, 9};
        vecs[3] = '{8'h01, 8'h01, 9};
        vecs[4] = '{8'h80, 8'h80, 9};
        vecs[5] = '{8'h7F, 8'h7F, 9};

        rst = 1'b1; soc = 0; rd = 0; ain = 0; soc3 = 0; rd3 = 0; ain3 = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_eoc", eoc, 1'b0);
        check("reset_dout", dout, 8'h00);
        check("reset_ovr", ovr, 1'b0);
        check("reset_eoc3", eoc3, 1'b0);

        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("rd_idle_eoc", eoc, 1'b0);
        check("rd_idle_ovr", ovr, 1'b0);

        for (int i = 0; i < 6; i++) begin
            conv(0, vecs[i].ain, 1'b0, 1'b0, lat);
            check("tbl_latency", lat, vecs[i].exp_lat);
            check("tbl_dout", dout, vecs[i].exp_dout);
            check("tbl_ovr", ovr, 1'b0);
            check("tbl_busy_done", busy, 1'b0);
            do_read(0);
            check("tbl_eoc_after_rd", eoc, 1'b0);
            check("tbl_dout_hold", dout, vecs[i].exp_dout);
        end

        conv(1, 8'h00, 1'b0, 1'b0, lat);
        check("div3_lat_00", lat, 25);
        check("div3_dout_00", dout3, 8'h00);
        do_read(1);
        conv(1, 8'hFF, 1'b0, 1'b0, lat);
        check("div3_lat_ff", lat, 25);
        check("div3_dout_ff", dout3, 8'hFF);
        do_read(1);

        // ain changes two cycles after soc
        soc = 1'b1; ain = 8'h3C;
        tick();
        soc = 1'b0;
        tick();
        ain = 8'hC3;
        lat = 0;
        while (!eoc && lat < 100) begin tick(); lat++; end
        check("ain_change_dout", dout, 8'h3C);
        do_read(0);

        // overrun by restart in DONE without rd
        conv(0, 8'hA1, 1'b0, 1'b0, lat);
        check("ovr_first_dout", dout, 8'hA1);
        conv(0, 8'h5E, 1'b0, 1'b0, lat);
        check("ovr_restart_lat", lat, 9);
        check("ovr_set", ovr, 1'b1);
        check("ovr_new_dout", dout, 8'h5E);
        do_read(0);
        check("ovr_rd_eoc", eoc, 1'b0);
        check("ovr_rd_clear", ovr, 1'b0);

        // soc during CONV
        soc = 1'b1; ain = 8'h96;
        tick();
        soc = 1'b0;
        lat = 0;
        while (!eoc && lat < 100) begin
            tick(); lat++;
            soc = (lat == 3);
        end
        soc = 1'b0;
        check("conv_soc_lat", lat, 9);
        check("conv_soc_ovr", ovr, 1'b1);
        check("conv_soc_dout", dout, 8'h96);
        do_read(0);
        check("conv_soc_rd_clear", ovr, 1'b0);

        // reset mid-conversion
        soc = 1'b1; ain = 8'h33;
        tick();
        soc = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_eoc", eoc, 1'b0);
        check("rst_mid_dout", dout, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_no_eoc", eoc, 1'b0);
        conv(0, 8'h5A, 1'b0, 1'b0, lat);
        check("rst_after_lat", lat, 9);
        check("rst_after_dout", dout, 8'h5A);

        // soc and rd together in DONE: read wins for ovr
        conv(0, 8'hE7, 1'b1, 1'b0, lat);
        check("socrd_ovr", ovr, 1'b0);
        check("socrd_dout", dout, 8'hE7);
        do_read(0);

        // randomized conversions against a reference model of the handshake
        pending = 0;
        ovr_exp = 0;
        for (int i = 0; i < 40; i++) begin
            a   = 8'($urandom);
            act = $urandom_range(0, 2);
            if (pending && act == 0) begin
                do_read(0);
                ovr_exp = 0;
                pending = 0;
                check("rnd_rd_eoc", eoc, 1'b0);
                check("rnd_rd_ovr", ovr, ovr_exp);
            end
            if (pending && act != 2) ovr_exp = 1;
            conv(0, a, (act == 2), $urandom_range(0, 1) == 1, lat);
            pending = 1;
            check("rnd_lat", lat, 9);
            check("rnd_dout", dout, a);
            check("rnd_ovr", ovr, ovr_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
